mem_port_arbiter: RTL

Arbitrates the single data-memory port between two requesters: committed stores draining from the LSQ and speculative loads issued by the LSQ. It sits between the LSQ and the data memory. It grants at most one access per cycle, registers the request onto the memory port, and tags the in-flight load. It then returns the sign- or zero-extended load result to the writeback/CDB stage with its physical destination register and ROB tag. Stores have priority, with a starvation guard for loads, and a pipeline flush squashes in-flight loads.

---
 rtl/mem_port_arbiter_pkg.sv | 49 ++++
 rtl/mem_port_arbiter_load_extend.sv | 23 ++
 rtl/mem_port_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and encodings for the data-memory port arbiter
package mem_port_arbiter_pkg;

    // Load func3 encodings as issued by the LSQ
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Memory access size encodings
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Tag field widths carried through the in-flight pipe; the arbiter's
    // PREG_W/ROB_W parameters default to these so the tag slots line up.
    localparam int LD_TAG_PREG_W = 7;
    localparam int LD_TAG_ROB_W  = 5;

    typedef enum logic {
        ST_PRIO = 1'b0,
        LD_PRIO = 1'b1
    } prio_state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
    } mem_req_t;

    typedef struct packed {
        logic                     valid;
        logic [2:0]               func3;
        logic [LD_TAG_PREG_W-1:0] pd;
        logic [LD_TAG_ROB_W-1:0]  rob;
    } ld_tag_t;

    // Unknown func3 values are issued as word reads; their result is zeroed later.
    function automatic logic [1:0] func3_to_size(input logic [2:0] func3);
        case (func3)
            F3_LB, F3_LBU: func3_to_size = SZ_BYTE;
            F3_LH, F3_LHU: func3_to_size = SZ_HALF;
            default:       func3_to_size = SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_port_arbiter_load_extend.sv
// rtl/mem_port_arbiter_load_extend.sv - sign/zero extension of a returned load word
module load_extend
    import mem_port_arbiter_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [31:0] word,
    output logic [31:0] result
);

    // Select the low byte/half and extend according to the load flavour
    always_comb begin
        result = '0;
        case (func3)
            F3_LB:   result = {{24{word[7]}}, word[7:0]};
            F3_LBU:  result = {24'h0, word[7:0]};
            F3_LH:   result = {{16{word[15]}}, word[15:0]};
            F3_LHU:  result = {16'h0, word[15:0]};
            F3_LW:   result = word;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - store/load arbitration onto the single data-memory port
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int ROB_W        = LD_TAG_ROB_W,
    parameter int PREG_W       = LD_TAG_PREG_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              st_valid,
    input  logic [31:0]       st_addr,
    input  logic [31:0]       st_data,
    input  logic [1:0]        st_size,
    output logic              st_ready,
    input  logic              ld_valid,
    input  logic [31:0]       ld_addr,
    input  logic [2:0]        ld_func3,
    input  logic [PREG_W-1:0] ld_pd,
    input  logic [ROB_W-1:0]  ld_rob,
    output logic              ld_ready,
    input  logic              mem_ready,
    output logic              mem_req_valid,
    output logic              mem_req_we,
    output logic [31:0]       mem_req_addr,
    output logic [31:0]       mem_req_wdata,
    output logic [1:0]        mem_req_size,
    input  logic              mem_resp_valid,
    input  logic [31:0]       mem_resp_data,
    output logic              ld_resp_valid,
    output logic [31:0]       ld_resp_data,
    output logic [PREG_W-1:0] ld_resp_pd,
    output logic [ROB_W-1:0]  ld_resp_rob
);

    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    prio_state_t      state_q;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    mem_req_t         req_q, req_d;
    logic             req_valid_q, req_valid_d;
    ld_tag_t          s1_q, s1_d;
    ld_tag_t          s2_q, s2_d;

    logic             can_grant;
    logic             req_accept;
    logic             ld_cand;
    logic             grant_st;
    logic             grant_ld;
    logic [31:0]      ext_data;

    // The request register may be refilled when empty or when it is being taken this cycle
    assign can_grant  = !req_valid_q || mem_ready;
    assign req_accept = req_valid_q && mem_ready;
    // A flush squashes the load presented in the same cycle
    assign ld_cand    = ld_valid && !flush;

    // Priority select between the store and load requesters
    always_comb begin
        grant_st = 1'b0;
        grant_ld = 1'b0;
        if (can_grant) begin
            if (state_q == LD_PRIO) begin
                grant_ld = ld_cand;
                grant_st = st_valid && !ld_cand;
            end else begin
                grant_st = st_valid;
                grant_ld = ld_cand && !st_valid;
            end
        end
    end

    assign st_ready = grant_st;
    assign ld_ready = grant_ld;

    // Saturating count of consecutive cycles a valid load has lost arbitration
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (flush || !ld_valid || grant_ld) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != CNT_MAX) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    // Priority FSM; switching on the counter reaching the limit lets the load win the very next cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_PRIO;
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            case (state_q)
                ST_PRIO: if (!flush && starve_cnt_d == CNT_MAX) state_q <= LD_PRIO;
                LD_PRIO: if (flush || grant_ld) state_q <= ST_PRIO;
                default: state_q <= ST_PRIO;
            endcase
        end
    end

    // Next contents of the memory request register
    always_comb begin
        req_d       = req_q;
        req_valid_d = req_valid_q;
        if (grant_st) begin
            req_d       = '{we: 1'b1, addr: st_addr, wdata: st_data, size: st_size};
            req_valid_d = 1'b1;
        end else if (grant_ld) begin
            req_d       = '{we: 1'b0, addr: ld_addr, wdata: 32'h0, size: func3_to_size(ld_func3)};
            req_valid_d = 1'b1;
        end else if (req_accept) begin
            req_valid_d = 1'b0;
        end
    end

    // In-flight load tags: stage 1 shadows the request register, stage 2 lines up with the response
    always_comb begin
        s1_d       = s1_q;
        s2_d       = s2_q;
        s2_d.valid = 1'b0;
        if (req_accept) begin
            s2_d = s1_q;
        end
        if (grant_st || grant_ld) begin
            s1_d = '{valid: grant_ld, func3: ld_func3, pd: ld_pd, rob: ld_rob};
        end else if (req_accept) begin
            s1_d.valid = 1'b0;
        end
        if (flush) begin
            s1_d.valid = 1'b0;
            s2_d.valid = 1'b0;
        end
    end

    // Request register and tag pipe state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_q       <= '0;
            req_valid_q <= 1'b0;
            s1_q        <= '0;
            s2_q        <= '0;
        end else begin
            req_q       <= req_d;
            req_valid_q <= req_valid_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
        end
    end

    assign mem_req_valid = req_valid_q;
    assign mem_req_we    = req_q.we;
    assign mem_req_addr  = req_q.addr;
    assign mem_req_wdata = req_q.wdata;
    assign mem_req_size  = req_q.size;

    load_extend u_load_extend (
        .func3  (s2_q.func3),
        .word   (mem_resp_data),
        .result (ext_data)
    );

    // Response fields are held at zero whenever no load result is being returned
    assign ld_resp_valid = s2_q.valid && mem_resp_valid && !flush;
    assign ld_resp_data  = ld_resp_valid ? ext_data : 32'h0;
    assign ld_resp_pd    = ld_resp_valid ? s2_q.pd  : '0;
    assign ld_resp_rob   = ld_resp_valid ? s2_q.rob : '0;

endmodule
